ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/riscv_pkg.sv | 117 +++++++++++
 rtl/mul_shift_add.sv | 80 ++++++++
 rtl/ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage definitions: opcodes, funct codes, ALUOp encodings,
// the internal ALU operation enum, multiplier FSM states and pure ALU helpers.
package riscv_pkg;

  localparam int unsigned Xlen = 32;

  // Major opcodes
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  // ALU funct3
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  // funct7
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;
  localparam logic [2:0] F3Mul    = 3'b000;

  // ALUOp from the decoder
  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRType  = 2'b10;
  localparam logic [1:0] AluOpIType  = 2'b11;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulBusy = 2'd1,
    MulDone = 2'd2
  } mul_state_e;

  // funct7[5] selects SUB only for R-type; ADDI has no subtract form, while the
  // same bit in the I-type immediate still selects SRAI over SRLI.
  function automatic alu_op_e alu_decode(logic [1:0] alu_op, logic [2:0] f3, logic f7_b5);
    alu_op_e op;
    op = AluAdd;
    if (alu_op == AluOpRType || alu_op == AluOpIType) begin
      case (f3)
        F3AddSub: op = (alu_op == AluOpRType && f7_b5) ? AluSub : AluAdd;
        F3Sll:    op = AluSll;
        F3Slt:    op = AluSlt;
        F3Sltu:   op = AluSltu;
        F3Xor:    op = AluXor;
        F3SrlSra: op = f7_b5 ? AluSra : AluSrl;
        F3Or:     op = AluOr;
        F3And:    op = AluAnd;
        default:  op = AluAdd;
      endcase
    end
    return op;
  endfunction

  function automatic logic [Xlen-1:0] alu_compute(alu_op_e op, logic [Xlen-1:0] a,
                                                  logic [Xlen-1:0] b);
    logic [Xlen-1:0] r;
    case (op)
      AluAdd:  r = a + b;
      AluSub:  r = a - b;
      AluSll:  r = a << b[4:0];
      AluSlt:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      AluSltu: r = (a < b) ? 32'd1 : 32'd0;
      AluXor:  r = a ^ b;
      AluSrl:  r = a >> b[4:0];
      AluSra:  r = $unsigned($signed(a) >>> b[4:0]);
      AluOr:   r = a | b;
      AluAnd:  r = a & b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic branch_cond(logic [2:0] f3, logic [Xlen-1:0] a, logic [Xlen-1:0] b);
    logic c;
    case (f3)
      F3Beq:   c = (a == b);
      F3Bne:   c = (a != b);
      F3Blt:   c = ($signed(a) < $signed(b));
      F3Bge:   c = ($signed(a) >= $signed(b));
      F3Bltu:  c = (a < b);
      F3Bgeu:  c = (a >= b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative 32x32 shift-add multiplier returning the low 32 bits of the product.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      accepted only in MulIdle; captures op_a_i/op_b_i
//   op_a_i/op_b_i operands
//   busy_o       high in MulBusy (32 cycles, one step per edge)
//   done_o       high for the single MulDone cycle; product_o is valid then
//   product_o    low 32 bits of op_a * op_b
module mul_shift_add
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [Xlen-1:0] op_a_i,
  input  logic [Xlen-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Xlen-1:0] product_o
);

  mul_state_e      state_q, state_d;
  logic [Xlen-1:0] mcand_q, mcand_d;
  logic [Xlen-1:0] mplier_q, mplier_d;
  logic [Xlen-1:0] acc_q, acc_d;
  logic [4:0]      count_q, count_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    case (state_q)
      MulIdle: begin
        if (start_i) begin
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
          acc_d    = '0;
          count_d  = 5'd31;
          state_d  = MulBusy;
        end
      end
      MulBusy: begin
        // Bits shifted past bit 31 are dropped: only the low word is kept.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == 5'd0) begin
          state_d = MulDone;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      MulDone: state_d = MulIdle;
      default: state_d = MulIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MulIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign busy_o    = (state_q == MulBusy);
  assign done_o    = (state_q == MulDone);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage with EX/MEM pipeline register, operand forwarding,
// branch resolution and a multi-cycle MUL.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   *_IDEX                ID/EX register contents and controls
//   write_Data/rd/RegWrite write-back port, forwarding source
//   *_EXMEM               EX/MEM register outputs
//   branch_taken/target   combinational redirect to IF/ID
//   ex_stall              holds PC, IF/ID and ID/EX while a MUL is running
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] read_data1_IDEX,
  input  logic [XLEN-1:0] read_data2_IDEX,
  input  logic [XLEN-1:0] PC_IDEX,
  input  logic [XLEN-1:0] imm_IDEX,
  input  logic [XLEN-1:0] instruc_IDEX,
  input  logic [4:0]      rd_IDEX,
  input  logic            branch_IDEX,
  input  logic            memRead_IDEX,
  input  logic            mem2reg_IDEX,
  input  logic            memWrite_IDEX,
  input  logic            ALUSrc_IDEX,
  input  logic            RegWrite_IDEX,
  input  logic [1:0]      ALUOp_IDEX,
  input  logic [XLEN-1:0] write_Data,
  input  logic [4:0]      rd,
  input  logic            RegWrite,
  output logic [XLEN-1:0] ALUResult_EXMEM,
  output logic [XLEN-1:0] writeData_EXMEM,
  output logic [4:0]      rd_EXMEM,
  output logic            memRead_EXMEM,
  output logic            mem2reg_EXMEM,
  output logic            memWrite_EXMEM,
  output logic            RegWrite_EXMEM,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_stall
);

  logic [4:0] rs1, rs2;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign rs1    = instruc_IDEX[19:15];
  assign rs2    = instruc_IDEX[24:20];
  assign opcode = instruc_IDEX[6:0];
  assign funct3 = instruc_IDEX[14:12];
  assign funct7 = instruc_IDEX[31:25];

  // rd is supplied separately by the decoder.
  logic unused_instr_rd;
  assign unused_instr_rd = ^instruc_IDEX[11:7];

  // EX/MEM register
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_read_q, mem_read_d;
  logic            mem2reg_q, mem2reg_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;

  // Forwarding: the younger EX/MEM result wins over write-back; x0 never forwards.
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    fwd_rs1 = read_data1_IDEX;
    if (reg_write_q && (rd_q != 5'd0) && (rd_q == rs1)) begin
      fwd_rs1 = alu_result_q;
    end else if (RegWrite && (rd != 5'd0) && (rd == rs1)) begin
      fwd_rs1 = write_Data;
    end
  end

  always_comb begin
    fwd_rs2 = read_data2_IDEX;
    if (reg_write_q && (rd_q != 5'd0) && (rd_q == rs2)) begin
      fwd_rs2 = alu_result_q;
    end else if (RegWrite && (rd != 5'd0) && (rd == rs2)) begin
      fwd_rs2 = write_Data;
    end
  end

  logic [XLEN-1:0] op_b;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_result;

  assign op_b       = ALUSrc_IDEX ? imm_IDEX : fwd_rs2;
  assign alu_op     = alu_decode(ALUOp_IDEX, funct3, funct7[5]);
  assign alu_result = alu_compute(alu_op, fwd_rs1, op_b);

  // Multiplier
  logic            is_mul, mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  assign is_mul    = (opcode == OpcodeOp) && (funct7 == F7MulDiv) && (funct3 == F3Mul);
  // In MulDone the MUL is still in ID/EX; it must not restart.
  assign mul_start = is_mul && !mul_busy && !mul_done;
  assign ex_stall  = mul_start || mul_busy;

  mul_shift_add u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .op_a_i    (fwd_rs1),
    .op_b_i    (fwd_rs2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Branch resolution
  logic is_branch;

  assign is_branch     = branch_IDEX || (ALUOp_IDEX == AluOpBranch);
  assign branch_taken  = branch_IDEX && branch_cond(funct3, fwd_rs1, fwd_rs2) && !ex_stall;
  assign branch_target = PC_IDEX + imm_IDEX;

  // EX/MEM next state: branches and stall cycles enter as all-zero bubbles.
  always_comb begin
    alu_result_d = '0;
    write_data_d = '0;
    rd_d         = '0;
    mem_read_d   = 1'b0;
    mem2reg_d    = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    if (mul_done) begin
      alu_result_d = mul_product;
      write_data_d = fwd_rs2;
      rd_d         = rd_IDEX;
      mem_read_d   = memRead_IDEX;
      mem2reg_d    = mem2reg_IDEX;
      mem_write_d  = memWrite_IDEX;
      reg_write_d  = RegWrite_IDEX;
    end else if (!ex_stall && !is_branch) begin
      alu_result_d = alu_result;
      write_data_d = fwd_rs2;
      rd_d         = rd_IDEX;
      mem_read_d   = memRead_IDEX;
      mem2reg_d    = mem2reg_IDEX;
      mem_write_d  = memWrite_IDEX;
      reg_write_d  = RegWrite_IDEX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      mem_read_q   <= 1'b0;
      mem2reg_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      mem_read_q   <= mem_read_d;
      mem2reg_q    <= mem2reg_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign ALUResult_EXMEM = alu_result_q;
  assign writeData_EXMEM = write_data_q;
  assign rd_EXMEM        = rd_q;
  assign memRead_EXMEM   = mem_read_q;
  assign mem2reg_EXMEM   = mem2reg_q;
  assign memWrite_EXMEM  = mem_write_q;
  assign RegWrite_EXMEM  = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and popped after the following clock edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data1_IDEX, read_data2_IDEX, PC_IDEX, imm_IDEX, instruc_IDEX;
  logic [4:0]  rd_IDEX;
  logic        branch_IDEX, memRead_IDEX, mem2reg_IDEX, memWrite_IDEX;
  logic        ALUSrc_IDEX, RegWrite_IDEX;
  logic [1:0]  ALUOp_IDEX;
  logic [31:0] write_Data;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] ALUResult_EXMEM, writeData_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic        memRead_EXMEM, mem2reg_EXMEM, memWrite_EXMEM, RegWrite_EXMEM;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_stall;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        rw;
  } exmem_t;

  exmem_t sb_q[$];

  ex_stage #(.XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_data1_IDEX (read_data1_IDEX),
    .read_data2_IDEX (read_data2_IDEX),
    .PC_IDEX         (PC_IDEX),
    .imm_IDEX        (imm_IDEX),
    .instruc_IDEX    (instruc_IDEX),
    .rd_IDEX         (rd_IDEX),
    .branch_IDEX     (branch_IDEX),
    .memRead_IDEX    (memRead_IDEX),
    .mem2reg_IDEX    (mem2reg_IDEX),
    .memWrite_IDEX   (memWrite_IDEX),
    .ALUSrc_IDEX     (ALUSrc_IDEX),
    .RegWrite_IDEX   (RegWrite_IDEX),
    .ALUOp_IDEX      (ALUOp_IDEX),
    .write_Data      (write_Data),
    .rd              (rd),
    .RegWrite        (RegWrite),
    .ALUResult_EXMEM (ALUResult_EXMEM),
    .writeData_EXMEM (writeData_EXMEM),
    .rd_EXMEM        (rd_EXMEM),
    .memRead_EXMEM   (memRead_EXMEM),
    .mem2reg_EXMEM   (mem2reg_EXMEM),
    .memWrite_EXMEM  (memWrite_EXMEM),
    .RegWrite_EXMEM  (RegWrite_EXMEM),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .ex_stall        (ex_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d, logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] s2, logic [4:0] s1);
    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [4:0] s2, logic [4:0] s1, logic [2:0] f3);
    return {7'b0, s2, s1, f3, 5'b0, 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu"}, ALUResult_EXMEM, 32'h0);
    check({tag, ".wd"}, writeData_EXMEM, 32'h0);
    check({tag, ".ctl"}, {27'h0, rd_EXMEM, memRead_EXMEM, mem2reg_EXMEM, memWrite_EXMEM,
                           RegWrite_EXMEM}, 32'h0);
    check({tag, ".stall"}, {31'h0, ex_stall}, 32'h0);
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] d,
                      input logic mr, input logic m2r, input logic mw, input logic rw);
    exmem_t e;
    e = '{alu: alu, wd: wd, rd: d, mr: mr, m2r: m2r, mw: mw, rw: rw};
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    push(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock edge, then compare EX/MEM against the oldest queued expectation.
  task automatic step(input string tag);
    exmem_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard required an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".alu"}, ALUResult_EXMEM, e.alu);
      check({tag, ".wd"}, writeData_EXMEM, e.wd);
      check({tag, ".rd"}, {27'h0, rd_EXMEM}, {27'h0, e.rd});
      check({tag, ".ctl"}, {28'h0, memRead_EXMEM, mem2reg_EXMEM, memWrite_EXMEM, RegWrite_EXMEM},
            {28'h0, e.mr, e.m2r, e.mw, e.rw});
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] pc, input logic [4:0] d,
                       input logic [1:0] aop, input logic src, input logic br,
                       input logic mr, input logic m2r, input logic mw, input logic rw);
    instruc_IDEX    = ins;
    read_data1_IDEX = r1;
    read_data2_IDEX = r2;
    imm_IDEX        = im;
    PC_IDEX         = pc;
    rd_IDEX         = d;
    ALUOp_IDEX      = aop;
    ALUSrc_IDEX     = src;
    branch_IDEX     = br;
    memRead_IDEX    = mr;
    mem2reg_IDEX    = m2r;
    memWrite_IDEX   = mw;
    RegWrite_IDEX   = rw;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] d, input logic [31:0] data);
    RegWrite   = rw;
    rd         = d;
    write_Data = data;
  endtask

  task automatic clear_idex();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_idex();
    set_wb(1'b0, 5'd0, 32'h0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding: x1 from EX/MEM, x2 from write-back
    drive(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0, 32'h0, 32'd5, 32'h0, 5'd1,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd5, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("addi_x1_5");
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'h0, 32'h0, 32'h0, 5'd3,
          2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_wb(1'b1, 5'd2, 32'd7);
    push(32'd12, 32'd7, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add_fwd");

    // EX/MEM beats write-back for the same register
    set_wb(1'b0, 5'd0, 32'h0);
    drive(enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0, 32'h0, 32'd10, 32'h0, 5'd1,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd10, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("addi_x1_10");
    drive(enc_i(12'd0, 5'd1, 3'b000, 5'd4, 7'b0010011), 32'h0, 32'h0, 32'd0, 32'h0, 5'd4,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_wb(1'b1, 5'd1, 32'd20);
    push(32'd10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    step("fwd_priority");

    // A write to x0 sitting in EX/MEM must not be forwarded
    set_wb(1'b0, 5'd0, 32'h0);
    drive(enc_i(12'd99, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'h0, 32'd99, 32'h0, 5'd0,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd99, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("addi_x0_99");
    drive(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h0, 32'h0, 32'd1, 32'h0, 5'd5,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd1, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    step("x0_no_fwd");

    // Branches: taken BEQ, then not-taken BNE; both enter EX/MEM as bubbles
    drive(enc_b(5'd7, 5'd6, 3'b000), 32'h55, 32'h55, 32'hFFFF_FFF8, 32'h100, 5'd0,
          2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("beq.taken", {31'h0, branch_taken}, 32'd1);
    check("beq.target", branch_target, 32'h0000_00F8);
    push_bubble();
    step("beq_bubble");
    drive(enc_b(5'd7, 5'd6, 3'b001), 32'h55, 32'h55, 32'hFFFF_FFF8, 32'h100, 5'd0,
          2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("bne.taken", {31'h0, branch_taken}, 32'd0);
    push_bubble();
    step("bne_bubble");

    // R-type ALU operations
    drive(enc_r(7'b0100000, 5'd21, 5'd20, 3'b000, 5'd10), 32'd100, 32'd30, 32'h0, 32'h0, 5'd10,
          2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd70, 32'd30, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    step("sub");
    drive(enc_r(7'b0100000, 5'd21, 5'd20, 3'b101, 5'd10), 32'h8000_0000, 32'd4, 32'h0, 32'h0,
          5'd10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'hF800_0000, 32'd4, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    step("sra");
    drive(enc_r(7'b0000000, 5'd21, 5'd20, 3'b101, 5'd10), 32'h8000_0000, 32'd4, 32'h0, 32'h0,
          5'd10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h0800_0000, 32'd4, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    step("srl");
    drive(enc_r(7'b0000000, 5'd21, 5'd20, 3'b011, 5'd11), 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0,
          5'd11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd1, 32'hFFFF_FFFF, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    step("sltu");
    drive(enc_r(7'b0000000, 5'd21, 5'd20, 3'b010, 5'd12), 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0,
          5'd12, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd0, 32'hFFFF_FFFF, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    step("slt");

    // Store and load address generation with memory controls
    drive(enc_s(12'd8, 5'd21, 5'd20), 32'h1000, 32'h0000_CAFE, 32'd8, 32'h0, 5'd0,
          2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'h1008, 32'h0000_CAFE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sw");
    drive(enc_i(12'd4, 5'd20, 3'b010, 5'd15, 7'b0000011), 32'h1000, 32'h0, 32'd4, 32'h0, 5'd15,
          2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h1004, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    step("lw");

    // MUL: 33 stall cycles of bubbles, product at edge 34
    drive(enc_r(7'b0000001, 5'd21, 5'd20, 3'b000, 5'd13), 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0,
          5'd13, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stall_cnt = 0;
    for (int e = 1; e <= 34; e++) begin
      #1;
      if (ex_stall) stall_cnt++;
      if (e == 1) check("mul.stall_first", {31'h0, ex_stall}, 32'd1);
      if (e == 34) check("mul.stall_done", {31'h0, ex_stall}, 32'd0);
      if (e <= 33) push_bubble();
      else push(32'hFFFF_FFFD, 32'd3, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1);
      step((e <= 33) ? "mul_bubble" : "mul_result");
    end
    check("mul.stall_cycles", stall_cnt, 32'd33);

    // MUL result forwarded from EX/MEM
    drive(enc_r(7'b0, 5'd0, 5'd13, 3'b000, 5'd14), 32'h0, 32'h0, 32'h0, 32'h0, 5'd14,
          2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'hFFFF_FFFD, 32'h0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    step("mul_fwd");

    // Reset while the multiplier is busy (counter at 10 after 22 edges)
    drive(enc_r(7'b0000001, 5'd21, 5'd20, 3'b000, 5'd13), 32'd6, 32'd7, 32'h0, 32'h0,
          5'd13, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 22; e++) begin
      push_bubble();
      step("mul2_bubble");
    end
    rst_n = 1'b0;
    clear_idex();
    #1;
    check_all_zero("busy_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(enc_r(7'b0, 5'd21, 5'd20, 3'b000, 5'd16), 32'd2, 32'd3, 32'h0, 32'h0, 5'd16,
          2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("post_reset.stall", {31'h0, ex_stall}, 32'd0);
    push(32'd5, 32'd3, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    step("post_reset_add");

    // Asynchronous reset clears a live EX/MEM entry immediately
    drive(enc_i(12'h7FF, 5'd0, 3'b000, 5'd17, 7'b0010011), 32'h0, 32'h0, 32'h7FF, 32'h0, 5'd17,
          2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h7FF, 32'h0, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    step("addi_7ff");
    rst_n = 1'b0;
    clear_idex();
    #1;
    check_all_zero("async_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
